// File: rtl/dram_pkg.sv
// Shared types and helpers for the dual-port distributed-RAM channel array.
package dram_pkg;

    typedef enum logic {INIT, READY} state_t;

    localparam int DEF_DEPTH     = 32;
    localparam int ADDR_W        = $clog2(DEF_DEPTH);
    localparam int SLICE_MAX_BUS = 1024;
    localparam int SLICE_MAX_W   = 64;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Channel c of a packed bus whose channels are w bits wide; caller truncates to w.
    function automatic logic [SLICE_MAX_W-1:0] ch_slice(input logic [SLICE_MAX_BUS-1:0] bus,
                                                        input int c, input int w);
        logic [SLICE_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SLICE_MAX_W; i++)
            if (i < w && (c * w + i) < SLICE_MAX_BUS)
                r[i] = bus[c * w + i];
        return r;
    endfunction

endpackage

// File: rtl/dram_dp_array_if.sv
// Control, write and read bus of the channel array; master drives, slave is the array.
interface dram_dp_array_if #(
    parameter int AW       = 5,
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 1
);
    logic                      clr;
    logic [CHANNELS-1:0]       we;
    logic [AW-1:0]             addr;
    logic [AW-1:0]             dpra;
    logic [CHANNELS*WIDTH-1:0] wdata;
    logic [CHANNELS*WIDTH-1:0] spo;
    logic [CHANNELS*WIDTH-1:0] dpo;
    logic                      busy;

    modport master (output clr, we, addr, dpra, wdata, input spo, dpo, busy);
    modport slave  (input clr, we, addr, dpra, wdata, output spo, dpo, busy);
endinterface

// File: rtl/dram_dp_channel.sv
// One DEPTH x WIDTH channel: single synchronous write port, two asynchronous read ports.
module dram_dp_channel #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_ra0,
    input  logic [AW-1:0]    i_ra1,
    output logic [WIDTH-1:0] o_rd0,
    output logic [WIDTH-1:0] o_rd1
);
    // Deliberately unreset; contents are defined only by the init sweep.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rd0 = r_mem[i_ra0];
    assign o_rd1 = r_mem[i_ra1];
endmodule

// File: rtl/dram_dp_array.sv
// Array of dual-port distributed-RAM channels with init/clear sweep and optional output register.
module dram_dp_array
    import dram_pkg::*;
#(
    parameter int               DEPTH     = 32,
    parameter int               WIDTH     = 1,
    parameter int               CHANNELS  = 2,
    parameter int               READ_REG  = 1,
    parameter logic [WIDTH-1:0] INIT_WORD = '0
) (
    input logic            clk,
    input logic            rst_n,
    dram_dp_array_if.slave bus
);
    localparam int AW = addr_w(DEPTH);
    localparam int BW = CHANNELS * WIDTH;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [AW-1:0]             r_cnt;
    logic                      w_busy;
    logic [CHANNELS-1:0]       w_we;
    logic [AW-1:0]             w_waddr;
    logic [SLICE_MAX_BUS-1:0]  w_wdata_ext;
    logic [BW-1:0]             w_rd_spo;
    logic [BW-1:0]             w_rd_dpo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (!bus.clr && r_cnt == AW'(DEPTH - 1)) w_state_nxt = READY;
            READY:   if (bus.clr) w_state_nxt = INIT;
            default: w_state_nxt = INIT;
        endcase
    end

    // clr mid-sweep restarts the sweep; the word at the current count is still written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_cnt <= '0;
        else if (bus.clr)             r_cnt <= '0;
        else if (r_state == INIT)     r_cnt <= r_cnt + 1'b1;
    end

    assign w_busy      = (r_state == INIT);
    assign bus.busy    = w_busy;
    assign w_waddr     = w_busy ? r_cnt : bus.addr;
    assign w_wdata_ext = {{(SLICE_MAX_BUS - BW){1'b0}}, bus.wdata};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] w_wd;

        // A clr in READY drops the user write of that cycle.
        assign w_we[c] = w_busy | (bus.we[c] & ~bus.clr);
        assign w_wd    = w_busy ? INIT_WORD : WIDTH'(ch_slice(w_wdata_ext, c, WIDTH));

        dram_dp_channel #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_ch (
            .i_clk   (clk),
            .i_we    (w_we[c]),
            .i_waddr (w_waddr),
            .i_wdata (w_wd),
            .i_ra0   (bus.addr),
            .i_ra1   (bus.dpra),
            .o_rd0   (w_rd_spo[c*WIDTH +: WIDTH]),
            .o_rd1   (w_rd_dpo[c*WIDTH +: WIDTH])
        );
    end

    if (READ_REG != 0) begin : g_reg
        logic [BW-1:0] r_spo;
        logic [BW-1:0] r_dpo;

        // Read-first: the array updates on the same edge, so the old word is captured.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_spo <= '0;
                r_dpo <= '0;
            end else begin
                r_spo <= w_busy ? '0 : w_rd_spo;
                r_dpo <= w_busy ? '0 : w_rd_dpo;
            end
        end

        // Gate as well, so the cycle right after clr already reads zero.
        assign bus.spo = w_busy ? '0 : r_spo;
        assign bus.dpo = w_busy ? '0 : r_dpo;
    end else begin : g_comb
        assign bus.spo = w_busy ? '0 : w_rd_spo;
        assign bus.dpo = w_busy ? '0 : w_rd_dpo;
    end
endmodule

// File: tb/tb_dram_dp_array.sv
// Scoreboard bench: one stimulus stream drives a registered-read and a combinational-read array.
module tb_dram_dp_array;
    localparam int         D  = 32;
    localparam int         W  = 2;
    localparam int         C  = 2;
    localparam int         AW = 5;
    localparam logic [1:0] IW = 2'b10;
    localparam logic [3:0] IV = {IW, IW};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_dp_array_if #(.AW(AW), .CHANNELS(C), .WIDTH(W)) ifa ();
    dram_dp_array_if #(.AW(AW), .CHANNELS(C), .WIDTH(W)) ifb ();

    dram_dp_array #(.DEPTH(D), .WIDTH(W), .CHANNELS(C), .READ_REG(1), .INIT_WORD(IW)) u_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa));
    dram_dp_array #(.DEPTH(D), .WIDTH(W), .CHANNELS(C), .READ_REG(0), .INIT_WORD(IW)) u_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb));

    typedef struct {
        string      tag;
        logic [3:0] spo;
        logic [3:0] dpo;
        bit         comb;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mdl[D];
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic clr, input logic [1:0] we, input logic [4:0] addr,
                       input logic [4:0] dpra, input logic [3:0] wd);
        ifa.clr = clr; ifa.we = we; ifa.addr = addr; ifa.dpra = dpra; ifa.wdata = wd;
        ifb.clr = clr; ifb.we = we; ifb.addr = addr; ifb.dpra = dpra; ifb.wdata = wd;
    endtask

    task automatic mdl_init();
        for (int i = 0; i < D; i++) mdl[i] = IV;
    endtask

    // One READY cycle: registered DUT expects pre-write words, combinational DUT post-write.
    task automatic step(input string tag, input logic clr, input logic [1:0] we,
                        input logic [4:0] addr, input logic [4:0] dpra, input logic [3:0] wd);
        exp_t ea, eb, e;
        drv(clr, we, addr, dpra, wd);
        ea.tag = {tag, "/reg"}; ea.comb = 1'b0;
        ea.spo = clr ? 4'h0 : mdl[addr];
        ea.dpo = clr ? 4'h0 : mdl[dpra];
        if (!clr)
            for (int c = 0; c < C; c++)
                if (we[c]) mdl[addr][c*W +: W] = wd[c*W +: W];
        eb.tag = {tag, "/comb"}; eb.comb = 1'b1;
        eb.spo = clr ? 4'h0 : mdl[addr];
        eb.dpo = clr ? 4'h0 : mdl[dpra];
        sb.push_back(ea);
        sb.push_back(eb);
        @(posedge clk); #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.comb) begin
                chk({e.tag, "_spo"}, 32'(ifb.spo), 32'(e.spo));
                chk({e.tag, "_dpo"}, 32'(ifb.dpo), 32'(e.dpo));
            end else begin
                chk({e.tag, "_spo"}, 32'(ifa.spo), 32'(e.spo));
                chk({e.tag, "_dpo"}, 32'(ifa.dpo), 32'(e.dpo));
            end
        end
    endtask

    task automatic wait_busy(input string tag, input int exp_n);
        int n = 0;
        while (ifa.busy === 1'b1 && n < 200) begin
            if (n % 8 == 3) begin
                chk({tag, "_spo0"}, 32'(ifa.spo | ifb.spo), 32'h0);
                chk({tag, "_dpo0"}, 32'(ifa.dpo | ifb.dpo), 32'h0);
            end
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'(exp_n));
        chk({tag, "_bsyb"}, 32'(ifb.busy), 32'h0);
    endtask

    task automatic sweep_all(input string tag);
        for (int a = 0; a < D; a++) step(tag, 1'b0, 2'b00, 5'(a), 5'(D - 1 - a), 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        drv(1'b0, 2'b00, 5'd0, 5'd0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(ifa.busy), 32'h1);
        chk("rst_spo",  32'(ifa.spo),  32'h0);
        chk("rst_dpo",  32'(ifa.dpo),  32'h0);
        rst_n = 1'b1;

        // Writes during the first 10 sweep cycles must be ignored.
        for (int i = 0; i < 10; i++) begin
            drv(1'b0, 2'b11, 5'(i), 5'(i), 4'h0);
            @(posedge clk); #1;
        end
        drv(1'b0, 2'b00, 5'd0, 5'd0, 4'h0);
        wait_busy("init", 22);
        mdl_init();
        sweep_all("sw0");

        step("wr5", 1'b0, 2'b01, 5'd5, 5'd0, 4'b1101);
        step("rd5", 1'b0, 2'b00, 5'd5, 5'd5, 4'h0);
        chk("rd5_lit", 32'(ifa.spo), 32'h9);
        step("wr9", 1'b0, 2'b10, 5'd9, 5'd5, 4'b0011);
        step("rd9", 1'b0, 2'b00, 5'd9, 5'd9, 4'h0);

        step("col",  1'b0, 2'b11, 5'd7, 5'd7, 4'b1111);
        step("col2", 1'b0, 2'b00, 5'd7, 5'd7, 4'h0);

        step("wr3",  1'b0, 2'b11, 5'd3, 5'd3, 4'b0101);
        step("rd3",  1'b0, 2'b00, 5'd3, 5'd3, 4'h0);
        step("clr",  1'b1, 2'b11, 5'd4, 5'd4, 4'h0);
        mdl_init();
        drv(1'b0, 2'b00, 5'd3, 5'd3, 4'h0);
        wait_busy("clr", 32);
        step("pc3", 1'b0, 2'b00, 5'd3, 5'd4, 4'h0);
        step("pc4", 1'b0, 2'b00, 5'd4, 5'd3, 4'h0);

        // Reset part-way through a sweep: word 20 is stale until the restarted sweep reaches it.
        step("wr20", 1'b0, 2'b11, 5'd20, 5'd0, 4'h0);
        step("clr2", 1'b1, 2'b00, 5'd0, 5'd0, 4'h0);
        mdl_init();
        drv(1'b0, 2'b00, 5'd20, 5'd20, 4'h0);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(ifa.busy), 32'h1);
        chk("mrst_out",  32'({ifa.spo, ifa.dpo}), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_busy("mrst", 32);
        sweep_all("sw1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dram_dp_array.md
Name: dram_dp_array

Overview:
- Parametrised array of dual-port distributed-RAM channels: one shared write/primary address, one shared secondary read address, per-channel write enables.
- Generalises the fixed 32x1 dual-port RAM pair to DEPTH x WIDTH x CHANNELS.
- Adds an optional read-output register, a hardware initialisation/clear sweep, and a busy indication.
- Used as the storage primitive in distributed-RAM feature tests and small register files.

Parameters:
- DEPTH, 32: words per channel; power of two, 16..256.
- WIDTH, 1: bits per word per channel.
- CHANNELS, 2: number of independent storage channels.
- READ_REG, 1: 1 = registered read outputs (1-cycle latency); 0 = combinational read.
- INIT_WORD, 1'b0 (WIDTH bits): value written to every word of every channel by the init sweep.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  pulse; requests a re-run of the init sweep.
- we  in  CHANNELS  per-channel write enable.
- addr  in  clog2(DEPTH)  write address and primary (SPO) read address.
- dpra  in  clog2(DEPTH)  secondary (DPO) read address.
- wdata  in  CHANNELS*WIDTH  write data; channel c occupies bits [c*WIDTH +: WIDTH].
- spo  out  CHANNELS*WIDTH  read data at addr, same channel packing.
- dpo  out  CHANNELS*WIDTH  read data at dpra, same channel packing.
- busy  out  1  high while the init sweep runs.

Behaviour:
- Storage is not reset. Only the sweep defines its contents.
- FSM states: INIT, READY.
- rst_n low (asynchronous): state=INIT, sweep counter=0, spo/dpo registers=0, busy=1.
- INIT:
  - Each cycle, write INIT_WORD to word[counter] in all channels, then counter+1.
  - After the write of word DEPTH-1, go to READY. The sweep takes exactly DEPTH cycles.
  - busy=1 throughout. First READY cycle has busy=0.
- READY: on a rising edge, for every c with we[c]=1, word[addr] of channel c is set to wdata[c].
- we, addr and wdata are ignored while busy=1. No write is queued.
- clr:
  - Sampled only in READY: clr=1 goes to INIT with counter=0; the write in that same cycle is dropped.
  - clr in INIT restarts the counter at 0, which extends the sweep.
- READ_REG=1:
  - spo/dpo register the array contents at addr/dpra on each edge; 1-cycle latency.
  - Read-first: a same-edge write to the read address returns the OLD word. The new word appears on the following edge.
- READ_REG=0:
  - spo/dpo are combinational reads of addr/dpra.
  - A write becomes visible immediately after the edge.
- Outputs are forced to 0 while busy=1, in both modes; READ_REG=1 registers load 0.
- Channels are independent: writing channel c never alters another channel.
- Address wrap: the counter wraps naturally; no out-of-range addresses exist.
- Async reset mid-sweep or mid-write: the sweep restarts from 0 after release, and array contents are rewritten.

Decomposition:
- Package dram_pkg holds:
  - state enum {INIT, READY};
  - the address-width localparam, computed as clog2(DEPTH);
  - a helper function that extracts a channel slice from a packed bus.
- Sub-module dram_dp_channel: one channel with a single write port and two async read ports (DEPTH x WIDTH). It is instantiated CHANNELS times through a generate loop.
- The FSM, sweep counter, write muxing (user vs. sweep) and output register/gating live in the top.

Test Plan:
(All scenarios use DEPTH=32, WIDTH=2, CHANNELS=2, READ_REG=1, INIT_WORD=2'b10 unless stated.)
- Reset release → busy=1 for exactly 32 cycles, then 0. Sweeping dpra over 0..31 gives dpo=4'b1010 at every address.
- we=2'b01, addr=5, wdata=4'b1101 → next cycle with addr=5, spo=4'b1001: ch0=01 written, ch1=10 untouched.
- Collision: write addr=7, wdata=4'b1111 with dpra=7 → dpo=4'b1010 on that edge, and 4'b1111 on the next edge.
- we=2'b11 with wdata=4'b0000 held during the first 10 busy cycles → after busy falls, every word still reads 4'b1010.
- Write addr=3 to 4'b0101, then pulse clr → busy for 32 cycles, spo/dpo=0 meanwhile; afterwards addr=3 reads 4'b1010.
- rst_n low at sweep cycle 12, release 3 cycles later → busy lasts 32 full cycles after release; all words read 4'b1010.
- Repeat the collision case with READ_REG=0 → dpo changes combinationally to 4'b1111 right after the write edge.
